logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Parametrised, pipelined successor to the six-gate bitwise block: applies one of eight selectable bitwise operations to two WIDTH-bit operands, with registered output, valid/ready flow control on both sides, and an accumulate mode that folds successive inputs into an internal register. It sits between a stimulus source (switch/UART front end) and a display or checker sink in the gates lab projects.

## Interface
- WIDTH, 8: operand and result width in bits (1..32).
- STAGES, 2: register stages from acceptance to output (1..4).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction offered.
- in_ready  out  1  block can accept this cycle.
- op  in  3  operation select: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A, 111 PASS A.
- acc_mode  in  1  1: second operand is the accumulator, not B.
- acc_clr  in  1  synchronous clear of the accumulator.
- A  in  WIDTH  first operand.
- B  in  WIDTH  second operand.
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts result this cycle.
- Z  out  WIDTH  result.
- zflag  out  1  Z is all zeros.
- pflag  out  1  XOR-reduction (odd parity) of Z.

## Operation
- Accept: in_valid & in_ready. Operands and op are sampled only on accept.
- Operand mux: opB = acc_mode ? acc : B. Ops 110/111 ignore opB.
- Result R = op(A, opB), bitwise over all WIDTH bits, no carry, no width growth.
- Accumulator acc (WIDTH bits, reset 0):
  - acc_clr = 1: acc <= 0 next edge, regardless of transactions.
  - else accept with acc_mode = 1: acc <= R.
  - else hold. Accepts with acc_mode = 0 never touch acc.
  - Simultaneous acc_clr and accepted acc_mode transaction: transaction uses the current (pre-clear) acc as opB; acc ends at 0.
- Pipeline: STAGES stages, each holding {valid, R}. R is computed combinationally before stage 1; later stages only delay it. zflag and pflag are derived combinationally from the last-stage R.
- Global stall: en = ~out_valid | out_ready. When en = 1, all stages shift by one. When en = 0, all stages hold. in_ready = en. Bubbles are not compressed.
- Output transfer: out_valid & out_ready. Z, zflag and pflag are stable while out_valid = 1 and out_ready = 0.

## Timing
- Reset (async assert, sync deassert seen at next edge): all stage valids 0, all stage data 0, acc 0.
  - Outputs under reset: out_valid 0, Z 0, zflag 1, pflag 0, in_ready 1.
- Latency: a result accepted at edge N is presented with out_valid = 1 after edge N+STAGES-1, i.e. visible for the cycle after edge N+STAGES-1, if there is no stall.
- Throughput: one transaction per cycle while out_ready = 1.
- Back-to-back acc_mode accepts: the second accept uses the first accept's R as opB, with no bubble.
- Stall: with out_valid = 1 and out_ready = 0, in_ready drops in the same cycle. No input is accepted and no data is lost or duplicated.
- in_valid = 0 with en = 1 inserts a bubble (valid 0) into stage 1.
- Reset mid-operation: all in-flight results are discarded and acc is lost. No output transfer completes on the reset cycle.
- acc_clr has no effect on in-flight results.

## Test plan
All scenarios use WIDTH = 8 and STAGES = 2.
- Reset values: assert rst_n = 0 mid-stream -> out_valid 0, Z 0x00, zflag 1, pflag 0, in_ready 1. Next acc_mode XOR with A = 0x00 -> Z 0x00, confirming acc = 0.
- All ops: A = 0xC5, B = 0x3A, op 000..111 streamed back-to-back with out_ready = 1 -> Z sequence 0x00, 0xFF, 0xFF, 0x00, 0xFF, 0x00, 0x3A, 0xC5.
  - Each result arrives 2 cycles after its accept.
  - zflag = 1 on 0x00 results; pflag = 0 on all eight results.
- Accumulate: acc_clr, then acc_mode XOR with A = 0x0F, 0xF0, 0x0F on consecutive cycles -> Z 0x0F, 0xFF, 0xF0. Then acc_mode AND with A = 0x30 -> Z 0x30.
- Clear collision: acc = 0xAA; accept acc_mode OR, A = 0x01, with acc_clr = 1 -> Z 0xAB. Next acc_mode OR, A = 0x01 -> Z 0x01.
- Backpressure: stream 6 XOR transactions, A = 0x01..0x06, B = 0x00, with out_ready held 0 for 4 cycles mid-stream.
  - in_ready follows en.
  - Output is exactly 0x01..0x06 in order: no drops, no duplicates.
  - Z is stable while stalled.
- Bubbles and parity: alternate in_valid 1/0 with PASS A = 0x07 -> out_valid toggles at the same rate, Z 0x07, pflag 1, zflag 0.

Source files
------------

// File: rtl/logic_unit_pipe_if.sv
// Handshake and operand bundle for logic_unit_pipe.
// The source/sink side uses master; the pipeline itself uses slave.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             acc_mode;
    logic             acc_clr;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Z;
    logic             zflag;
    logic             pflag;

    modport master (
        output in_valid, op, acc_mode, acc_clr, A, B, out_ready,
        input  in_ready, out_valid, Z, zflag, pflag
    );

    modport slave (
        input  in_valid, op, acc_mode, acc_clr, A, B, out_ready,
        output in_ready, out_valid, Z, zflag, pflag
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined eight-op bitwise unit with accumulator and valid/ready flow control.
// One global enable shifts or holds every stage; bubbles are kept, not squeezed out.
module logic_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    logic_unit_pipe_if.slave bus
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] r;
    logic             en;
    logic             accept;

    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  dat [STAGES];

    assign en     = ~vld[STAGES-1] | bus.out_ready;
    assign accept = bus.in_valid & en;
    assign op_b   = bus.acc_mode ? acc : bus.B;

    always_comb begin
        r = '0;
        case (bus.op)
            3'b000:  r = bus.A & op_b;
            3'b001:  r = bus.A | op_b;
            3'b010:  r = ~(bus.A & op_b);
            3'b011:  r = ~(bus.A | op_b);
            3'b100:  r = bus.A ^ op_b;
            3'b101:  r = ~(bus.A ^ op_b);
            3'b110:  r = ~bus.A;
            default: r = bus.A;
        endcase
    end

    // Clear wins over an accumulating accept; that accept still saw the old acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (bus.acc_clr) begin
            acc <= '0;
        end else if (accept && bus.acc_mode) begin
            acc <= r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dat[i] <= '0;
            end
        end else if (en) begin
            vld[0] <= bus.in_valid;
            if (bus.in_valid) begin
                dat[0] <= r;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = vld[STAGES-1];
    assign bus.Z         = dat[STAGES-1];
    assign bus.zflag     = ~|dat[STAGES-1];
    assign bus.pflag     = ^dat[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH 8, STAGES 2) with directed vectors.
module tb_logic_unit_pipe;

    typedef struct {
        logic [7:0] z;
        int         acy;
        bit         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    logic_unit_pipe_if #(.WIDTH(8)) bus ();

    logic_unit_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [2:0] o, input logic am, input logic ac,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] z, input bit lat);
        bit done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.op       = o;
            bus.acc_mode = am;
            bus.acc_clr  = ac;
            bus.A        = a;
            bus.B        = b;
            #1;
            if (bus.in_ready) begin
                q.push_back('{z: z, acy: cyc + 1, lat: lat});
                done = 1'b1;
            end
            @(posedge clk);
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input logic ac);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.acc_clr  = ac;
            @(posedge clk);
        end
        @(negedge clk);
        bus.acc_clr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        chk("drain_left", q.size(), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_Z", bus.Z, 8'h00);
        chk("rst_zflag", bus.zflag, 1'b1);
        chk("rst_pflag", bus.pflag, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
    endtask

    // Monitor: pops on every transfer, also watches stall stability and in_ready.
    initial begin
        exp_t       e;
        bit         held_v = 1'b0;
        logic [7:0] held_z = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("in_ready_en", bus.in_ready, !bus.out_valid || bus.out_ready);
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", bus.Z, 8'hxx);
                    end else begin
                        e = q.pop_front();
                        chk("Z", bus.Z, e.z);
                        chk("zflag", bus.zflag, ~|e.z);
                        chk("pflag", bus.pflag, ^e.z);
                        if (e.lat) chk("latency", cyc - e.acy, 1);
                    end
                end
                if (bus.out_valid && !bus.out_ready) begin
                    if (held_v) chk("stall_Z_stable", bus.Z, held_z);
                    held_v = 1'b1;
                    held_z = bus.Z;
                end else begin
                    held_v = 1'b0;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops_z [8];
        ops_z = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3A, 8'hC5};
        bus.in_valid = 1'b0; bus.op = 3'b000; bus.acc_mode = 1'b0; bus.acc_clr = 1'b0;
        bus.A = '0; bus.B = '0; bus.out_ready = 1'b1;

        #12;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // All eight ops, back-to-back, latency checked.
        for (int i = 0; i < 8; i++) send(3'(i), 1'b0, 1'b0, 8'hC5, 8'h3A, ops_z[i], 1'b1);
        idle(1, 1'b0);
        drain();

        // Accumulate.
        idle(1, 1'b1);
        send(3'b100, 1'b1, 1'b0, 8'h0F, 8'h55, 8'h0F, 1'b0);
        send(3'b100, 1'b1, 1'b0, 8'hF0, 8'h55, 8'hFF, 1'b0);
        send(3'b100, 1'b1, 1'b0, 8'h0F, 8'h55, 8'hF0, 1'b0);
        send(3'b000, 1'b1, 1'b0, 8'h30, 8'h55, 8'h30, 1'b0);
        idle(1, 1'b0);
        drain();

        // Clear collision: acc = 0xAA, then OR with clear, then OR again.
        idle(1, 1'b1);
        send(3'b100, 1'b1, 1'b0, 8'hAA, 8'h00, 8'hAA, 1'b0);
        send(3'b001, 1'b1, 1'b1, 8'h01, 8'h00, 8'hAB, 1'b0);
        send(3'b001, 1'b1, 1'b0, 8'h01, 8'h00, 8'h01, 1'b0);
        idle(1, 1'b0);
        drain();

        // Backpressure mid-stream.
        fork
            begin
                for (int a = 1; a <= 6; a++) send(3'b100, 1'b0, 1'b0, 8'(a), 8'h00, 8'(a), 1'b0);
                idle(1, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (4) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Bubbles with PASS A = 0x07.
        for (int i = 0; i < 4; i++) begin
            send(3'b111, 1'b0, 1'b0, 8'h07, 8'h00, 8'h07, 1'b0);
            #2;
            chk("bubble_valid_lo", bus.out_valid, 1'b0);
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(posedge clk);
            #2;
            chk("bubble_valid_hi", bus.out_valid, 1'b1);
            chk("bubble_pflag", bus.pflag, 1'b1);
            chk("bubble_zflag", bus.zflag, 1'b0);
        end
        idle(1, 1'b0);
        drain();

        // Reset mid-stream with acc nonzero (acc = 0x01 from the collision test).
        send(3'b100, 1'b1, 1'b0, 8'h10, 8'h00, 8'h11, 1'b0);
        send(3'b111, 1'b0, 1'b0, 8'h22, 8'h00, 8'h22, 1'b0);
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk_reset_outputs();
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(3'b100, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0);
        idle(1, 1'b0);
        drain();

        idle(3, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
